// File: rtl/branch_pred_unit.sv
// Branch predictor: 2-bit saturating BHT plus an in-flight FIFO of predicted branches, resolved oldest-first.
// Latency: prediction is combinational (0 cycles); a resolve produces flush/npc_corr on the next edge.
// Backpressure: pred_ready drops when the queue has no free slot this cycle or a flush is pending.
// Optional statistics counters are enabled by defining BRANCH_PRED_STATS_EN.
module branch_pred_unit #(
   parameter int WordSize = 32,
   parameter int BhtDepth = 16,
   parameter int QDepth   = 4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                pred_valid,
   input  logic [WordSize-1:0] pred_pc,
   input  logic [WordSize-1:0] pred_target,
   output logic                pred_ready,
   output logic                pred_taken,
   output logic [WordSize-1:0] pred_npc,
   input  logic                res_valid,
   input  logic [1:0]          res_cond,
   input  logic [WordSize-1:0] alu_out,
   output logic                flush,
   output logic [WordSize-1:0] npc_corr,
   output logic [31:0]         stat_branches,
   output logic [31:0]         stat_mispred
);

   localparam int IW = $clog2(BhtDepth);
   localparam int QW = $clog2(QDepth);
   localparam logic [QW:0] QFull = QDepth[QW:0];

   typedef struct packed {
      logic [IW-1:0]       idx;
      logic                taken;
      logic [WordSize-1:0] target;
      logic [WordSize-1:0] pc4;
   } entry_t;

   logic [1:0]    bht [BhtDepth];
   entry_t        q_mem [QDepth];
   logic [QW-1:0] wr_ptr, rd_ptr;
   logic [QW:0]   count;

   logic [IW-1:0]       pred_idx;
   logic [WordSize-1:0] pred_pc4;
   entry_t              head;
   logic                full, empty, push, res_fire, act_taken, mispred;

   assign pred_idx   = pred_pc[IW+1:2];
   assign pred_pc4   = pred_pc + WordSize'(4);
   assign pred_taken = bht[pred_idx][1];
   assign pred_npc   = pred_taken ? pred_target : pred_pc4;

   assign full  = (count == QFull);
   assign empty = (count == '0);
   // A full queue still accepts when the head pops this same cycle; a mispredicting
   // pop later discards the push anyway.
   assign pred_ready = (!full || res_valid) && !flush;
   assign push       = pred_valid && pred_ready;

   assign head     = q_mem[rd_ptr];
   assign res_fire = res_valid && !empty;

   always_comb begin
      act_taken = 1'b0;
      case (res_cond)
         2'b00: act_taken = 1'b0;
         2'b01: act_taken = (alu_out == '0);
         2'b10: act_taken = (alu_out != '0);
         2'b11: act_taken = 1'b1;
         default: act_taken = 1'b0;
      endcase
   end

   assign mispred = res_fire && (act_taken != head.taken);

   always_ff @(posedge clk) begin
      if (push && !mispred) q_mem[wr_ptr] <= '{pred_idx, pred_taken, pred_target, pred_pc4};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (mispred) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)     wr_ptr <= wr_ptr + 1'b1;
         if (res_fire) rd_ptr <= rd_ptr + 1'b1;
         if (push && !res_fire)      count <= count + 1'b1;
         else if (!push && res_fire) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < BhtDepth; i++) bht[i] <= 2'b01;
      end else if (res_fire) begin
         if (act_taken && bht[head.idx] != 2'b11)       bht[head.idx] <= bht[head.idx] + 2'd1;
         else if (!act_taken && bht[head.idx] != 2'b00) bht[head.idx] <= bht[head.idx] - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         flush    <= 1'b0;
         npc_corr <= '0;
      end else begin
         flush <= mispred;
         if (mispred) npc_corr <= act_taken ? head.target : head.pc4;
      end
   end

`ifdef BRANCH_PRED_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else begin
         if (res_fire) stat_branches <= stat_branches + 32'd1;
         if (mispred)  stat_mispred  <= stat_mispred + 32'd1;
      end
   end
`else
   assign stat_branches = '0;
   assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_branch_pred_unit;
   localparam int W  = 32;
   localparam int BD = 16;
   localparam int QD = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          pred_valid = 1'b0;
   logic [W-1:0]  pred_pc = '0, pred_target = '0;
   logic          pred_ready, pred_taken;
   logic [W-1:0]  pred_npc;
   logic          res_valid = 1'b0;
   logic [1:0]    res_cond = '0;
   logic [W-1:0]  alu_out = '0;
   logic          flush;
   logic [W-1:0]  npc_corr;
   logic [31:0]   stat_branches, stat_mispred;

   branch_pred_unit #(.WordSize(W), .BhtDepth(BD), .QDepth(QD)) dut (
      .clk(clk), .rstn(rstn),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_target(pred_target),
      .pred_ready(pred_ready), .pred_taken(pred_taken), .pred_npc(pred_npc),
      .res_valid(res_valid), .res_cond(res_cond), .alu_out(alu_out),
      .flush(flush), .npc_corr(npc_corr),
      .stat_branches(stat_branches), .stat_mispred(stat_mispred)
   );

   always #5 clk = ~clk;

`ifdef BRANCH_PRED_STATS_EN
   localparam bit StatsOn = 1'b1;
`else
   localparam bit StatsOn = 1'b0;
`endif

   typedef struct {
      int       idx;
      bit       tk;
      logic [W-1:0] tgt;
      logic [W-1:0] pc4;
   } ent_t;

   int       bht_m [BD];
   ent_t     q_m [$];
   bit       flush_m;
   logic [W-1:0] npc_m;
   int unsigned  sb_m, sm_m;
   int       checks = 0;
   int       errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < BD; i++) bht_m[i] = 1;
      q_m.delete();
      flush_m = 0;
      npc_m = '0;
      sb_m = 0;
      sm_m = 0;
   endtask

   function automatic int idx_of(input logic [W-1:0] pc);
      return int'((pc >> 2) % BD);
   endfunction

   function automatic bit ready_m();
      return !flush_m && (q_m.size() < QD || res_valid);
   endfunction

   function automatic bit act_m();
      case (res_cond)
         2'd0: return 0;
         2'd1: return alu_out == 0;
         2'd2: return alu_out != 0;
         default: return 1;
      endcase
   endfunction

   // Drive one cycle's inputs, then compare every output with the model.
   task automatic drive(input bit pv, input logic [W-1:0] pc, input logic [W-1:0] tgt,
                        input bit rv, input logic [1:0] cond, input logic [W-1:0] alu);
      bit tk;
      pred_valid = pv; pred_pc = pc; pred_target = tgt;
      res_valid = rv; res_cond = cond; alu_out = alu;
      #1;
      tk = bht_m[idx_of(pc)] >= 2;
      chk("pred_taken", pred_taken, tk);
      chk("pred_npc", pred_npc, tk ? tgt : pc + 4);
      chk("pred_ready", pred_ready, ready_m());
      chk("flush", flush, flush_m);
      chk("npc_corr", npc_corr, npc_m);
      chk("stat_branches", stat_branches, StatsOn ? sb_m : 0);
      chk("stat_mispred", stat_mispred, StatsOn ? sm_m : 0);
   endtask

   // Advance the model by the clock edge, then step the DUT to the next falling edge.
   task automatic tick();
      bit   push, tk, act, nf;
      ent_t h, e;
      push = pred_valid && ready_m();
      tk   = bht_m[idx_of(pred_pc)] >= 2;
      act  = act_m();
      nf   = 0;
      if (res_valid && q_m.size() > 0) begin
         h = q_m.pop_front();
         if (act) bht_m[h.idx] = (bht_m[h.idx] < 3) ? bht_m[h.idx] + 1 : 3;
         else     bht_m[h.idx] = (bht_m[h.idx] > 0) ? bht_m[h.idx] - 1 : 0;
         sb_m++;
         if (act != h.tk) begin
            nf = 1;
            sm_m++;
            npc_m = act ? h.tgt : h.pc4;
            q_m.delete();
         end
      end
      if (push && !nf) begin
         e.idx = idx_of(pred_pc); e.tk = tk; e.tgt = pred_target; e.pc4 = pred_pc + 4;
         q_m.push_back(e);
      end
      flush_m = nf;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      drive(0, '0, '0, 0, 2'd0, '0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #2;
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      #1;
      chk("rst_flush", flush, 1'b0);
      chk("rst_npc_corr", npc_corr, 32'h0);
      chk("rst_stat_branches", stat_branches, 32'h0);
      chk("rst_stat_mispred", stat_mispred, 32'h0);
      @(negedge clk);
      rstn = 1'b1;

      // First prediction after reset, then an always-taken resolve mispredicts.
      drive(1, 32'h100, 32'h200, 0, 2'd0, '0);
      chk("r33_taken", pred_taken, 1'b0);
      chk("r33_npc", pred_npc, 32'h104);
      chk("r33_ready", pred_ready, 1'b1);
      tick();
      drive(0, '0, '0, 1, 2'd3, '0);
      tick();
      idle();
      chk("r34_flush", flush, 1'b1);
      chk("r34_npc_corr", npc_corr, 32'h200);
      tick();
      drive(1, 32'h100, 32'h200, 0, 2'd0, '0);
      chk("r34_repredict", pred_taken, 1'b1);
      chk("r34_flush_gone", flush, 1'b0);
      tick();
      drive(0, '0, '0, 1, 2'd3, '0);
      tick();

      // Fill the queue, then push alongside a correct resolve while full.
      for (int i = 0; i < QD; i++) begin
         drive(1, 32'h304 + 4 * i, 32'h800, 0, 2'd0, '0);
         tick();
      end
      drive(1, 32'h314, 32'h900, 0, 2'd0, '0);
      chk("r35_full_ready", pred_ready, 1'b0);
      tick();
      drive(1, 32'h314, 32'h900, 1, 2'd0, '0);
      chk("r35_push_resolve_ready", pred_ready, 1'b1);
      tick();
      drive(1, 32'h318, 32'h900, 0, 2'd0, '0);
      chk("r35_still_full", pred_ready, 1'b0);
      tick();
      for (int i = 0; i < QD; i++) begin
         drive(0, '0, '0, 1, 2'd0, '0);
         tick();
      end

      // Three in flight, the oldest mispredicts: flush once, then a stray resolve is ignored.
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h320 + 4 * i, 32'hA00 + 4 * i, 0, 2'd0, '0);
         tick();
      end
      drive(0, '0, '0, 1, 2'd1, 32'h0);
      tick();
      idle();
      chk("r36_flush", flush, 1'b1);
      chk("r36_npc_corr", npc_corr, 32'hA00);
      tick();
      drive(0, '0, '0, 1, 2'd3, '0);
      chk("r36_flush_one_cycle", flush, 1'b0);
      tick();
      idle();
      chk("r36_ignored", flush, 1'b0);
      tick();

      // Saturation at one index: four taken, then one not-taken.
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h130, 32'h500, 0, 2'd0, '0);
         tick();
         drive(0, '0, '0, 1, 2'd2, 32'h5);
         tick();
         idle();
         tick();
      end
      drive(1, 32'h130, 32'h500, 0, 2'd0, '0);
      chk("r37_saturated", pred_taken, 1'b1);
      tick();
      drive(0, '0, '0, 1, 2'd0, '0);
      tick();
      drive(0, 32'h130, 32'h500, 0, 2'd0, '0);
      chk("r37_after_nt", pred_taken, 1'b1);
      chk("r37_flush", flush, 1'b1);
      chk("r37_npc_corr", npc_corr, 32'h134);
      tick();

      // Statistics: five resolves, two mispredicts, from a fresh reset.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 32'h104, 32'h700, 0, 2'd0, '0);
         tick();
         drive(0, '0, '0, 1, (i == 2 || i == 4) ? 2'd3 : 2'd0, '0);
         tick();
         idle();
         tick();
      end
      idle();
      chk("r38_branches", stat_branches, StatsOn ? 32'd5 : 32'd0);
      chk("r38_mispred", stat_mispred, StatsOn ? 32'd2 : 32'd0);
      tick();

      // Randomized traffic with aliasing PCs and a mid-run reset.
      for (int n = 0; n < 3000; n++) begin
         logic [W-1:0] alu;
         alu = ($urandom_range(1) == 0) ? '0 : $urandom;
         drive($urandom_range(1), 32'h1000 + 4 * $urandom_range(31), $urandom,
               $urandom_range(2) == 0, 2'($urandom_range(3)), alu);
         if (n == 1500) begin
            do_reset();
            idle();
         end else begin
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
